// File: rtl/sram_pix_pkg.sv
// Shared types and constants for the SRAM pixel fetch stage.
// Holds the FSM state enum, RGB565 field positions and the default frame geometry.
package sram_pix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        READ = 2'd2,
        FILL = 2'd3
    } spf_state_e;

    localparam int DEF_IMG_W  = 640;
    localparam int DEF_IMG_H  = 480;
    localparam int DEF_ADDR_W = 20;

    // RGB565 word layout {R, G, B}
    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

endpackage

// File: rtl/sram_addr_gen.sv
// Combinational pixel-to-word address map (Y*IMG_W + X) with frame bounds check.
module sram_addr_gen
    import sram_pix_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [9:0]        x_i,
    input  logic [9:0]        y_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              in_range_o
);

    // Product is formed at full address width so large rows cannot wrap early.
    assign addr_o     = ADDR_W'(y_i) * ADDR_W'(IMG_W) + ADDR_W'(x_i);
    assign in_range_o = ({22'd0, x_i} < 32'(IMG_W)) && ({22'd0, y_i} < 32'(IMG_H));

endmodule

// File: rtl/sram_pixel_fetch.sv
// Fetches one RGB565 pixel per request from the shared frame SRAM; out-of-frame requests get FILL_RGB.
// Optional one-entry last-hit cache enabled by defining SPF_LAST_HIT_EN.
module sram_pixel_fetch
    import sram_pix_pkg::*;
#(
    parameter int          IMG_W    = DEF_IMG_W,
    parameter int          IMG_H    = DEF_IMG_H,
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter int          RD_WAIT  = 2,
    parameter logic [15:0] FILL_RGB = 16'h0000
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iREQ,
    input  logic [9:0]        iX,
    input  logic [9:0]        iY,
    input  logic              iFLUSH,
    output logic              oREADY,
    output logic [4:0]        oR,
    output logic [5:0]        oG,
    output logic [4:0]        oB,
    output logic              oBUSY,
    output logic              oDROP,
    output logic              oSRAM_REQ,
    input  logic              iSRAM_GNT,
    output logic [ADDR_W-1:0] oSRAM_ADDR,
    input  logic [15:0]       iSRAM_DQ,
    output logic              oSRAM_CE_N,
    output logic              oSRAM_OE_N,
    output logic              oSRAM_UB_N,
    output logic              oSRAM_LB_N,
    output logic              oSRAM_WE_N
);

    spf_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              drop_q, drop_d;
    logic              req_q, req_d;
    logic              ce_n_q, ce_n_d;
    logic [15:0]       rgb_q, rgb_d;
    logic [15:0]       fill_q, fill_d;

    logic [ADDR_W-1:0] ag_addr;
    logic              ag_in_range;
    logic              accept;
    logic              capture;
    logic              hit;
    logic [15:0]       hit_rgb;

    sram_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .x_i        (iX),
        .y_i        (iY),
        .addr_o     (ag_addr),
        .in_range_o (ag_in_range)
    );

    // busy_q stays high through the oREADY cycle, so it alone gates acceptance.
    assign accept  = iREQ && !busy_q;
    assign capture = (state_q == READ) && (cnt_q == 4'(RD_WAIT - 1));

`ifdef SPF_LAST_HIT_EN
    logic              cv_q, cv_d;
    logic              fs_q, fs_d;
    logic [ADDR_W-1:0] ca_q, ca_d;
    logic [15:0]       cd_q, cd_d;

    assign hit     = cv_q && !iFLUSH && (ca_q == ag_addr);
    assign hit_rgb = cd_q;

    always_comb begin
        cv_d = cv_q;
        ca_d = ca_q;
        cd_d = cd_q;
        fs_d = fs_q;
        if (accept) begin
            fs_d = iFLUSH;
        end else if (iFLUSH) begin
            fs_d = 1'b1;
        end
        // A flush seen anywhere during the read keeps stale data out of the cache.
        if (capture && !fs_q && !iFLUSH) begin
            cv_d = 1'b1;
            ca_d = addr_q;
            cd_d = iSRAM_DQ;
        end
        if (iFLUSH) begin
            cv_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cv_q <= 1'b0;
            fs_q <= 1'b0;
            ca_q <= '0;
            cd_q <= '0;
        end else begin
            cv_q <= cv_d;
            fs_q <= fs_d;
            ca_q <= ca_d;
            cd_q <= cd_d;
        end
    end
`else
    logic unused_flush;
    assign unused_flush = iFLUSH;
    assign hit          = 1'b0;
    assign hit_rgb      = FILL_RGB;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        drop_d  = iREQ && busy_q;
        req_d   = req_q;
        ce_n_d  = ce_n_q;
        rgb_d   = rgb_q;
        fill_d  = fill_q;
        if (ready_q) begin
            busy_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    busy_d = 1'b1;
                    addr_d = ag_addr;
                    if (!ag_in_range) begin
                        state_d = FILL;
                        fill_d  = FILL_RGB;
                    end else if (hit) begin
                        state_d = FILL;
                        fill_d  = hit_rgb;
                    end else begin
                        state_d = ARB;
                        req_d   = 1'b1;
                    end
                end
            end
            ARB: begin
                if (iSRAM_GNT) begin
                    state_d = READ;
                    cnt_d   = '0;
                    ce_n_d  = 1'b0;
                end
            end
            READ: begin
                // Grant is not re-checked here; the arbiter never revokes mid-read.
                if (capture) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    rgb_d   = iSRAM_DQ;
                    ce_n_d  = 1'b1;
                    req_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            FILL: begin
                state_d = IDLE;
                ready_d = 1'b1;
                rgb_d   = fill_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            drop_q  <= 1'b0;
            req_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            rgb_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            drop_q  <= drop_d;
            req_q   <= req_d;
            ce_n_q  <= ce_n_d;
            rgb_q   <= rgb_d;
            fill_q  <= fill_d;
        end
    end

    assign oREADY     = ready_q;
    assign oBUSY      = busy_q;
    assign oDROP      = drop_q;
    assign oR         = rgb_q[R_MSB:R_LSB];
    assign oG         = rgb_q[G_MSB:G_LSB];
    assign oB         = rgb_q[B_MSB:B_LSB];
    assign oSRAM_REQ  = req_q;
    assign oSRAM_ADDR = addr_q;
    assign oSRAM_CE_N = ce_n_q;
    assign oSRAM_OE_N = ce_n_q;
    assign oSRAM_UB_N = ce_n_q;
    assign oSRAM_LB_N = ce_n_q;
    assign oSRAM_WE_N = 1'b1;

endmodule
